// File: rtl/exsram_target.sv
// -----------------------------------------------------------------------------
// exsram_target
//   SRAM-side end of the HS32 external multiplexed 16-bit SRAM bus. Decodes the
//   two-phase address latch (ALE0 = A[16:1], ALE1 = BLE# + A[31:17]) and serves
//   OE reads / WE writes from an internal byte-laned word array. Used in place of
//   the external latch + SRAM pair for FPGA emulation and system benches.
//
// Parameters
//   ADDR_W   word-address width; array depth is 2**ADDR_W x 16 bits
//   BASE_HI  A[31:17] value this target responds to
//
// Ports
//   clk      clock; all bus inputs sampled on posedge
//   reset_n  asynchronous active-low reset
//   ad_in    multiplexed address/data from the initiator
//   ale0     ad_in carries A[16:1]
//   ale1     ad_in[15] = BLE# (0 = low byte enabled), ad_in[14:0] = A[31:17]
//   oe       read data phase
//   we       write data phase
//   bhe      high byte lane enabled for this data phase
//   ad_out   read data (disabled lanes forced to 0)
//   ad_oe    target drives ad_out onto the bus
//   hit      latched address decodes to this target
//   err      sticky protocol error, cleared only by reset
// -----------------------------------------------------------------------------
module exsram_target #(
  parameter int          ADDR_W  = 10,
  parameter logic [14:0] BASE_HI = 15'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] ad_in,
  input  logic        ale0,
  input  logic        ale1,
  input  logic        oe,
  input  logic        we,
  input  logic        bhe,
  output logic [15:0] ad_out,
  output logic        ad_oe,
  output logic        hit,
  output logic        err
);

  // Bus phase tracker, used only to detect protocol violations.
  localparam logic [1:0] ST_IDLE = 2'd0;  // no transaction in progress
  localparam logic [1:0] ST_ADDR = 2'd1;  // ALE seen, waiting for data phase
  localparam logic [1:0] ST_DATA = 2'd2;  // oe or we active

  logic [15:0]       mem [2**ADDR_W];

  // Only the word-index bits of A[16:1] are kept: higher bits alias anyway.
  logic [ADDR_W-1:0] lo_q;
  logic [14:0]       hi_q;
  logic              ble_n_q;
  logic [15:0]       rd_q;      // prefetched word at the latched index
  logic              upd_q;     // a latch updated last cycle -> refresh rd_q
  logic              armed_q;   // some ALE seen since reset
  logic [1:0]        state_q;
  logic [1:0]        state_d;

  logic              ale_any;
  logic              ale_one;
  logic              ale_clash;
  logic              data_ph;
  logic              orphan;
  logic              rd_cyc;
  logic              wr_cyc;
  logic              err_set;
  logic [15:0]       lane_mask;
  logic [15:0]       cur_word;
  logic [15:0]       merged;

  assign hit = (hi_q == BASE_HI);

  always_comb begin
    ale_any   = ale0 | ale1;
    ale_one   = ale0 ^ ale1;
    ale_clash = ale0 & ale1;
    data_ph   = oe | we;

    // A data phase with no address ever latched since reset is refused.
    orphan    = data_ph && (state_q == ST_IDLE) && !armed_q;

    rd_cyc    = oe && !we && !orphan;
    wr_cyc    = we && !oe && hit && !orphan;

    // Low lane from the latched BLE#, high lane from the live bhe.
    lane_mask = {{8{bhe}}, {8{~ble_n_q}}};
    cur_word  = mem[lo_q];
    merged    = (ad_in & lane_mask) | (cur_word & ~lane_mask);

    err_set   = ale_clash | (ale_any & data_ph) | (oe & we) | orphan;
  end

  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (ale_any)                 state_d = ST_ADDR;
        else if (data_ph && armed_q) state_d = ST_DATA;
      end
      ST_ADDR: begin
        if (data_ph) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (!data_ph) state_d = ale_any ? ST_ADDR : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lo_q    <= '0;
      hi_q    <= '0;
      ble_n_q <= 1'b1;
      rd_q    <= '0;
      upd_q   <= 1'b0;
      armed_q <= 1'b0;
      state_q <= ST_IDLE;
      ad_oe   <= 1'b0;
      ad_out  <= '0;
      err     <= 1'b0;
    end else begin
      if (ale0 && !ale1) lo_q <= ad_in[ADDR_W-1:0];
      if (ale1 && !ale0) begin
        hi_q    <= ad_in[14:0];
        ble_n_q <= ad_in[15];
      end
      upd_q   <= ale_one;
      if (ale_any) armed_q <= 1'b1;
      state_q <= state_d;

      // Write bypass keeps rd_q coherent with the array after a write.
      if (wr_cyc)     rd_q <= merged;
      else if (upd_q) rd_q <= cur_word;

      ad_oe  <= rd_cyc && hit;
      ad_out <= rd_cyc ? (rd_q & lane_mask) : 16'h0000;

      if (err_set) err <= 1'b1;
    end
  end

  // NOTE: the array is deliberately not reset; contents survive reset_n.
  always_ff @(posedge clk) begin
    if (wr_cyc) begin
      if (!ble_n_q) mem[lo_q][7:0]  <= ad_in[7:0];
      if (bhe)      mem[lo_q][15:8] <= ad_in[15:8];
    end
  end

endmodule

// File: tb/tb_exsram_target.sv
// -----------------------------------------------------------------------------
// tb_exsram_target
//   Directed scenarios plus a randomized transaction phase for exsram_target.
//   The reference model keeps the bus-visible state (latched address, BLE#,
//   A[31:17], word contents) as plain variables and an associative array.
// -----------------------------------------------------------------------------
module tb_exsram_target;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] ad_in;
  logic        ale0, ale1, oe, we, bhe;
  logic [15:0] ad_out;
  logic        ad_oe, hit, err;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [15:0] mem_m [int];
  logic [15:0] lo_m;
  logic [14:0] hi_m;
  logic        ble_n_m;

  exsram_target #(.ADDR_W(10), .BASE_HI(15'h0)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .ad_in  (ad_in),
    .ale0   (ale0),
    .ale1   (ale1),
    .oe     (oe),
    .we     (we),
    .bhe    (bhe),
    .ad_out (ad_out),
    .ad_oe  (ad_oe),
    .hit    (hit),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one bus cycle starting at the falling edge.
  task automatic drive(input logic a0, input logic a1, input logic o, input logic w,
                       input logic b, input logic [15:0] d);
    @(negedge clk);
    ale0 = a0; ale1 = a1; oe = o; we = w; bhe = b; ad_in = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic ale1_cyc(input logic ble_n, input logic [14:0] hi);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {ble_n, hi});
    hi_m    = hi;
    ble_n_m = ble_n;
  endtask

  task automatic ale0_cyc(input logic [15:0] a);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a);
    lo_m = a;
  endtask

  function automatic int widx_m();
    return int'(lo_m % 16'd1024);
  endfunction

  function automatic logic hit_m();
    return hi_m == 15'h0;
  endfunction

  function automatic logic [15:0] exp_read(input logic b);
    logic [15:0] v;
    v = mem_m.exists(widx_m()) ? mem_m[widx_m()] : 16'hxxxx;
    if (ble_n_m) v[7:0]  = 8'h00;
    if (!b)      v[15:8] = 8'h00;
    return v;
  endfunction

  task automatic model_reset();
    lo_m    = 16'h0000;
    hi_m    = 15'h0;
    ble_n_m = 1'b1;
  endtask

  task automatic write_txn(input logic [15:0] d, input logic b, input int ncyc);
    logic [15:0] v;
    for (int k = 0; k < ncyc; k++) drive(1'b0, 1'b0, 1'b0, 1'b1, b, d);
    if (hit_m()) begin
      v = mem_m.exists(widx_m()) ? mem_m[widx_m()] : 16'hxxxx;
      if (!ble_n_m) v[7:0]  = d[7:0];
      if (b)        v[15:8] = d[15:8];
      mem_m[widx_m()] = v;
    end
    idle();
  endtask

  // OE for ncyc cycles; outputs are checked one cycle after each sampled oe.
  task automatic read_txn(input logic b, input int ncyc, input string tag);
    logic [15:0] e;
    e = exp_read(b);
    for (int k = 0; k < ncyc; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, b, 16'($urandom));
      if (k == 0) check({tag, "_oe_lag"}, {15'b0, ad_oe}, 16'h0000);
      else begin
        check({tag, "_oe"}, {15'b0, ad_oe}, {15'b0, hit_m()});
        if (hit_m()) check({tag, "_data"}, ad_out, e);
      end
    end
    idle();
    check({tag, "_oe"}, {15'b0, ad_oe}, {15'b0, hit_m()});
    if (hit_m()) check({tag, "_data"}, ad_out, e);
    idle();
    check({tag, "_oe_off"}, {15'b0, ad_oe}, 16'h0000);
  endtask

  initial begin
    ale0 = 0; ale1 = 0; oe = 0; we = 0; bhe = 0; ad_in = 16'h0000;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_hit",    {15'b0, hit},   16'h0001);
    check("rst_err",    {15'b0, err},   16'h0000);
    check("rst_ad_oe",  {15'b0, ad_oe}, 16'h0000);
    check("rst_ad_out", ad_out,         16'h0000);

    // T1: full-word write to word 5
    ale1_cyc(1'b0, 15'h0);
    ale0_cyc(16'h0005);
    idle();
    write_txn(16'hBEEF, 1'b1, 1);
    check("t1_hit", {15'b0, hit}, 16'h0001);
    check("t1_err", {15'b0, err}, 16'h0000);

    // T2: ALE0 only (held A[31:17]/BLE#), read back
    ale0_cyc(16'h0005);
    idle();
    read_txn(1'b1, 1, "t2");
    check("t2_value", exp_read(1'b1), 16'hBEEF);

    // T3: BLE# off -> high lane only; then OE with both lanes disabled
    ale1_cyc(1'b1, 15'h0);
    ale0_cyc(16'h0005);
    idle();
    write_txn(16'h1234, 1'b1, 1);
    read_txn(1'b0, 1, "t3_nolanes");

    // T4: miss -> no write, no drive
    ale1_cyc(1'b0, 15'h0001);
    idle();
    check("t4_hit", {15'b0, hit}, 16'h0000);
    write_txn(16'hFFFF, 1'b1, 1);
    read_txn(1'b1, 1, "t4_miss");
    ale1_cyc(1'b0, 15'h0);
    ale0_cyc(16'h0005);
    idle();
    read_txn(1'b1, 1, "t4_keep");
    check("t3_merge", exp_read(1'b1), 16'h12EF);
    check("t4_err", {15'b0, err}, 16'h0000);

    // Randomized phase: preload 16 words, then random transactions with aliasing
    ale1_cyc(1'b0, 15'h0);
    for (int i = 0; i < 16; i++) begin
      ale0_cyc(16'(i));
      idle();
      write_txn(16'($urandom), 1'b1, 1);
    end
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0 || !hit_m())
        ale1_cyc(1'($urandom), ($urandom_range(0, 5) == 0) ? 15'h0001 : 15'h0);
      ale0_cyc((16'($urandom) & 16'hFC00) | 16'($urandom_range(0, 15)));
      idle();
      if ($urandom_range(0, 1) == 0)
        write_txn(16'($urandom), 1'($urandom), int'($urandom_range(1, 2)));
      else
        read_txn(1'($urandom), int'($urandom_range(1, 3)), "rnd");
    end
    check("rnd_err", {15'b0, err}, 16'h0000);

    // T5: ALE0/ALE1 clash -> latches hold, err set
    ale1_cyc(1'b0, 15'h0);
    ale0_cyc(16'h0005);
    idle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0001);
    idle();
    check("t5_clash_err", {15'b0, err}, 16'h0001);
    check("t5_clash_hit", {15'b0, hit}, 16'h0001);
    read_txn(1'b1, 1, "t5_lo_held");
    // oe and we together: no write, no drive
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h5555);
    idle();
    check("t5_oewe_oe",  {15'b0, ad_oe}, 16'h0000);
    check("t5_oewe_err", {15'b0, err},   16'h0001);
    read_txn(1'b1, 1, "t5_nowrite");
    check("t5_sticky", {15'b0, err}, 16'h0001);
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("t5_err_clr", {15'b0, err}, 16'h0000);

    // T6: reset during a read drops ad_oe asynchronously
    ale1_cyc(1'b0, 15'h0);
    ale0_cyc(16'h0005);
    idle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    check("t6_oe_on", {15'b0, ad_oe}, 16'h0001);
    #2 reset_n = 1'b0;
    #1 check("t6_async_oe", {15'b0, ad_oe}, 16'h0000);
    model_reset();
    @(negedge clk);
    oe = 1'b0; bhe = 1'b0;
    reset_n = 1'b1;
    // OE without any ALE since reset
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    idle();
    check("t6_orphan_err", {15'b0, err},   16'h0001);
    check("t6_orphan_oe",  {15'b0, ad_oe}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
